// File: rtl/ctl_mni_op_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ctl_mni_op_fetch
// Purpose  : Fetches the 8 descriptor halfwords of the CTL MNI register block
//            on each operation-start pulse. Packs them into a 128-bit command
//            and queues it in a FIFO. Issues commands to the network engine
//            over valid/ready and tracks issued, not-yet-done commands.
// Revision : 1.0 - initial release
// ============================================================================
module ctl_mni_op_fetch #(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic         clk_ni,
    input  logic         rst_ni,
    input  logic         i_op_start,
    output logic [3:0]   o_reg_rd_adr,
    input  logic [15:0]  i_reg_rd_data,
    output logic         o_cmd_valid,
    output logic [127:0] o_cmd_data,
    input  logic         i_cmd_ready,
    input  logic         i_cmd_done,
    output logic [5:0]   o_cpu_fifo_ops,
    output logic [5:0]   o_net_fifo_ops,
    output logic         o_busy,
    output logic         o_op_overflow,
    input  logic         i_err_clr
);

    localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [5:0] DEPTH_C = 6'(FIFO_DEPTH);
    localparam logic [5:0] MAX_C   = 6'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [2:0]      idx;
    logic [15:0]     hw [7];
    logic [127:0]    mem [FIFO_DEPTH];
    logic [127:0]    push_data;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [5:0]      occ;
    logic [5:0]      outst;
    logic            overflow;

    logic            fifo_full;
    logic            start_ok;
    logic            drop;
    logic            push;
    logic            pop;
    logic            done_ok;

    // Occupancy is evaluated before any same-edge pop, so a start racing
    // the pop of the last free slot is still treated as a full-FIFO drop.
    assign fifo_full   = (occ >= DEPTH_C);
    assign start_ok    = (state == IDLE) & i_op_start & ~fifo_full;
    assign drop        = i_op_start & ((state == FETCH) | fifo_full);
    assign push        = (state == FETCH) & (idx == 3'd7);
    assign o_cmd_valid = (occ != 6'd0) & (outst < MAX_C);
    assign pop         = o_cmd_valid & i_cmd_ready;
    assign done_ok     = i_cmd_done & (outst != 6'd0);

    assign o_reg_rd_adr   = (state == FETCH) ? {1'b0, idx} : 4'd0;
    assign o_busy         = (state == FETCH);
    assign o_cmd_data     = mem[rd_ptr];
    assign o_cpu_fifo_ops = occ;
    assign o_net_fifo_ops = outst;
    assign o_op_overflow  = overflow;

    // FSM state register
    always_ff @(posedge clk_ni or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nx;
    end

    // FSM next state: one fetch runs exactly eight cycles
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = FETCH;
            FETCH:   if (idx == 3'd7) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Fetch index and halfword capture; the last halfword goes straight to the FIFO
    always_ff @(posedge clk_ni or negedge rst_ni) begin
        if (!rst_ni) begin
            idx <= 3'd0;
            for (int k = 0; k < 7; k++) hw[k] <= 16'd0;
        end else if (start_ok) begin
            idx <= 3'd0;
        end else if (state == FETCH) begin
            idx <= idx + 3'd1;
            if (idx != 3'd7) hw[idx] <= i_reg_rd_data;
        end
    end

    // Assemble the command from captured halfwords plus the live last one
    always_comb begin
        push_data = '0;
        for (int k = 0; k < 7; k++) push_data[16*k +: 16] = hw[k];
        push_data[127:112] = i_reg_rd_data;
    end

    // Command FIFO storage and pointers; storage is cleared so the head reads 0 after reset
    always_ff @(posedge clk_ni or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Occupancy and outstanding counters; simultaneous inc/dec cancel
    always_ff @(posedge clk_ni or negedge rst_ni) begin
        if (!rst_ni) begin
            occ   <= 6'd0;
            outst <= 6'd0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + 6'd1;
                2'b01:   occ <= occ - 6'd1;
                default: occ <= occ;
            endcase
            case ({pop, done_ok})
                2'b10:   outst <= outst + 6'd1;
                2'b01:   outst <= outst - 6'd1;
                default: outst <= outst;
            endcase
        end
    end

    // Sticky dropped-start flag; a new drop wins over a clear
    always_ff @(posedge clk_ni or negedge rst_ni) begin
        if (!rst_ni)        overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
        else if (i_err_clr) overflow <= 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_ctl_mni_op_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctl_mni_op_fetch
// Purpose  : Scoreboard bench for ctl_mni_op_fetch (FIFO_DEPTH 4,
//            MAX_OUTSTANDING 2) using directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctl_mni_op_fetch;

    logic         clk_ni = 1'b0;
    logic         rst_ni = 1'b0;
    logic         op_start = 1'b0;
    logic [3:0]   reg_rd_adr;
    logic [15:0]  reg_rd_data;
    logic         cmd_valid;
    logic [127:0] cmd_data;
    logic         cmd_ready = 1'b0;
    logic         cmd_done = 1'b0;
    logic [5:0]   cpu_fifo_ops;
    logic [5:0]   net_fifo_ops;
    logic         busy;
    logic         op_overflow;
    logic         err_clr = 1'b0;

    logic [15:0]  regs [16];
    logic [127:0] exp_q [$];
    int           tests = 0;
    int           fails = 0;

    ctl_mni_op_fetch #(
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_ni         (clk_ni),
        .rst_ni         (rst_ni),
        .i_op_start     (op_start),
        .o_reg_rd_adr   (reg_rd_adr),
        .i_reg_rd_data  (reg_rd_data),
        .o_cmd_valid    (cmd_valid),
        .o_cmd_data     (cmd_data),
        .i_cmd_ready    (cmd_ready),
        .i_cmd_done     (cmd_done),
        .o_cpu_fifo_ops (cpu_fifo_ops),
        .o_net_fifo_ops (net_fifo_ops),
        .o_busy         (busy),
        .o_op_overflow  (op_overflow),
        .i_err_clr      (err_clr)
    );

    always #5 clk_ni = ~clk_ni;

    // Register block model: combinational read of the halfword array
    assign reg_rd_data = regs[reg_rd_adr];

    task automatic tick(input int n);
        repeat (n) @(posedge clk_ni);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_regs(input logic [15:0] base);
        for (int k = 0; k < 16; k++) regs[k] = 16'hDEAD;
        for (int k = 0; k < 8; k++) regs[k] = base + 16'(k);
    endtask

    function automatic logic [127:0] pack_regs(input logic [15:0] base);
        logic [127:0] v;
        for (int k = 0; k < 8; k++) v[16*k +: 16] = base + 16'(k);
        return v;
    endfunction

    // Raise start so it is sampled at the next edge (E0); returns just after E0
    task automatic pulse_start();
        op_start = 1'b1;
        tick(1);
        op_start = 1'b0;
    endtask

    // Issue an op expected to be accepted: expectation enters the scoreboard
    task automatic issue_op(input logic [15:0] base);
        set_regs(base);
        exp_q.push_back(pack_regs(base));
        pulse_start();
    endtask

    // Monitor: every accepted handshake must match the oldest expected command
    always @(negedge clk_ni) begin
        if (rst_ni && cmd_valid && cmd_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got %0h expected no command", cmd_data);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (cmd_data !== e) begin
                    fails++;
                    $display("FAIL pop_data: got %0h expected %0h", cmd_data, e);
                end
            end
        end
    end

    initial begin
        set_regs(16'h0000);
        // ---------------- reset state
        #2;
        chk("rst_valid", 128'(cmd_valid), 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_adr", 128'(reg_rd_adr), 0);
        chk("rst_data", cmd_data, 0);
        tick(2);
        rst_ni = 1'b1;
        tick(1);

        // ---------------- single op
        cmd_ready = 1'b1;
        issue_op(16'h1110);
        chk("t1_busy", 128'(busy), 1);
        chk("t1_adr0", 128'(reg_rd_adr), 0);
        tick(7);
        chk("t1_adr7", 128'(reg_rd_adr), 7);
        chk("t1_valid_early", 128'(cmd_valid), 0);
        tick(1);
        chk("t1_valid", 128'(cmd_valid), 1);
        chk("t1_busy_off", 128'(busy), 0);
        chk("t1_hw0", 128'(cmd_data[15:0]), 128'h1110);
        chk("t1_hw7", 128'(cmd_data[127:112]), 128'h1117);
        tick(1);
        chk("t1_net", 128'(net_fifo_ops), 1);
        chk("t1_cpu", 128'(cpu_fifo_ops), 0);
        cmd_ready = 1'b0;
        cmd_done = 1'b1;
        tick(1);
        cmd_done = 1'b0;
        chk("t1_net_done", 128'(net_fifo_ops), 0);

        // ---------------- fill: four accepted, fifth dropped
        for (int i = 0; i < 4; i++) begin
            issue_op(16'h2000 + 16'(16 * i));
            tick(8);
        end
        chk("t2_cpu_full", 128'(cpu_fifo_ops), 4);
        chk("t2_ovf_before", 128'(op_overflow), 0);
        set_regs(16'h2F00);
        pulse_start();
        chk("t2_drop_busy", 128'(busy), 0);
        chk("t2_ovf", 128'(op_overflow), 1);
        chk("t2_cpu_still", 128'(cpu_fifo_ops), 4);
        // drain with done held so the outstanding limit never blocks
        cmd_ready = 1'b1;
        cmd_done = 1'b1;
        tick(8);
        chk("t2_cpu_empty", 128'(cpu_fifo_ops), 0);
        chk("t2_net_zero", 128'(net_fifo_ops), 0);
        chk("t2_valid_off", 128'(cmd_valid), 0);
        cmd_ready = 1'b0;
        cmd_done = 1'b0;
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t2_ovf_clr", 128'(op_overflow), 0);

        // ---------------- busy drop
        issue_op(16'h3000);
        tick(2);
        op_start = 1'b1;
        tick(1);
        op_start = 1'b0;
        chk("t3_ovf", 128'(op_overflow), 1);
        chk("t3_busy", 128'(busy), 1);
        tick(5);
        chk("t3_cpu1", 128'(cpu_fifo_ops), 1);
        issue_op(16'h3100);
        tick(2);
        op_start = 1'b1;
        err_clr = 1'b1;
        tick(1);
        op_start = 1'b0;
        err_clr = 1'b0;
        chk("t3_set_wins", 128'(op_overflow), 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t3_clr", 128'(op_overflow), 0);
        tick(4);
        chk("t3_cpu2", 128'(cpu_fifo_ops), 2);
        cmd_ready = 1'b1;
        cmd_done = 1'b1;
        tick(5);
        cmd_ready = 1'b0;
        cmd_done = 1'b0;
        chk("t3_cpu0", 128'(cpu_fifo_ops), 0);
        chk("t3_net0", 128'(net_fifo_ops), 0);

        // ---------------- outstanding limit (MAX_OUTSTANDING = 2)
        for (int i = 0; i < 3; i++) begin
            issue_op(16'h4000 + 16'(16 * i));
            tick(8);
        end
        chk("t4_cpu3", 128'(cpu_fifo_ops), 3);
        cmd_ready = 1'b1;
        tick(3);
        chk("t4_net2", 128'(net_fifo_ops), 2);
        chk("t4_cpu1", 128'(cpu_fifo_ops), 1);
        chk("t4_valid_blocked", 128'(cmd_valid), 0);
        cmd_done = 1'b1;
        tick(1);
        cmd_done = 1'b0;
        chk("t4_net_after_done", 128'(net_fifo_ops), 1);
        tick(1);
        chk("t4_net_stays2", 128'(net_fifo_ops), 2);
        chk("t4_cpu0", 128'(cpu_fifo_ops), 0);

        // ---------------- coincident pop and done
        cmd_ready = 1'b0;
        cmd_done = 1'b1;
        tick(1);
        cmd_done = 1'b0;
        chk("t5_net1", 128'(net_fifo_ops), 1);
        issue_op(16'h5500);
        tick(8);
        chk("t5_valid", 128'(cmd_valid), 1);
        cmd_ready = 1'b1;
        cmd_done = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        chk("t5_pop_done_net", 128'(net_fifo_ops), 1);
        chk("t5_cpu0", 128'(cpu_fifo_ops), 0);
        tick(3);
        cmd_done = 1'b0;
        chk("t5_done_at_zero", 128'(net_fifo_ops), 0);

        // ---------------- reset mid-fetch
        set_regs(16'h5000);
        pulse_start();
        tick(1);
        op_start = 1'b1;
        tick(1);
        op_start = 1'b0;
        chk("t6_ovf", 128'(op_overflow), 1);
        tick(2);
        chk("t6_adr4", 128'(reg_rd_adr), 4);
        rst_ni = 1'b0;
        #1;
        chk("t6_busy", 128'(busy), 0);
        chk("t6_adr", 128'(reg_rd_adr), 0);
        chk("t6_ovf_rst", 128'(op_overflow), 0);
        chk("t6_data", cmd_data, 0);
        tick(2);
        rst_ni = 1'b1;
        tick(1);
        chk("t6_cpu", 128'(cpu_fifo_ops), 0);
        chk("t6_valid", 128'(cmd_valid), 0);
        cmd_ready = 1'b1;
        issue_op(16'h6000);
        chk("t6_adr0", 128'(reg_rd_adr), 0);
        tick(8);
        chk("t6_valid_new", 128'(cmd_valid), 1);
        tick(2);
        cmd_ready = 1'b0;
        chk("t6_net", 128'(net_fifo_ops), 1);

        chk("scoreboard_empty", 128'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
